// File: rtl/fwrisc_imem_pkg.sv
// Shared types for the instruction-memory responder: FSM state encoding
// and the wait-state counter width.
package fwrisc_imem_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD0,
    RD1,
    RESP
  } imem_state_e;

endpackage

// File: rtl/fwrisc_imem_responder.sv
// Instruction fetch responder: turns a held ivalid/iaddr request into one or
// two synchronous memory reads and a single-cycle iready/idata response.
module fwrisc_imem_responder
  import fwrisc_imem_pkg::*;
#(
  parameter int WAIT_STATES      = 0,
  parameter int MEM_ADDR_W       = 12,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           iaddr,
  input  logic                  ivalid,
  output logic [31:0]           idata,
  output logic                  iready,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [31:0]           mem_rdata
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

  imem_state_e             state_reg, state_next;
  logic [MEM_ADDR_W-1:0]   word_addr_reg;
  logic                    split_reg;
  logic [WAIT_CNT_W-1:0]   wait_cnt_reg;
  logic [15:0]             held_reg;

  // Byte lane bit and aliased upper address bits never reach memory.
  logic unused_iaddr;
  assign unused_iaddr = ^{iaddr[31:MEM_ADDR_W+2], iaddr[0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      word_addr_reg <= '0;
      split_reg     <= 1'b0;
      wait_cnt_reg  <= '0;
      held_reg      <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (ivalid) begin
            word_addr_reg <= iaddr[MEM_ADDR_W+1:2];
            split_reg     <= (SPLIT_MISALIGNED != 0) && iaddr[1];
            wait_cnt_reg  <= WAIT_INIT;
          end
        end
        WAIT:    wait_cnt_reg <= wait_cnt_reg - 1'b1;
        // First word is on mem_rdata during RD1; keep its upper half.
        RD1:     held_reg <= mem_rdata[31:16];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    iready     = 1'b0;
    idata      = '0;
    case (state_reg)
      IDLE: begin
        if (ivalid) state_next = (WAIT_STATES > 0) ? WAIT : RD0;
      end
      WAIT: begin
        if (wait_cnt_reg == WAIT_CNT_W'(1)) state_next = RD0;
      end
      RD0: begin
        mem_rd     = 1'b1;
        mem_addr   = word_addr_reg;
        state_next = split_reg ? RD1 : RESP;
      end
      RD1: begin
        mem_rd     = 1'b1;
        mem_addr   = word_addr_reg + MEM_ADDR_W'(1);
        state_next = RESP;
      end
      RESP: begin
        iready     = 1'b1;
        idata      = split_reg ? {mem_rdata[15:0], held_reg} : mem_rdata;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fwrisc_imem_responder.sv
// Bench for fwrisc_imem_responder: two instances (0 and 3 wait states), each
// with a synchronous-read memory, checked against a transaction-level model.
module fwrisc_imem_sram_model #(
  parameter int AW = 12
) (
  input  logic          clock,
  input  logic          rd,
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata
);
  logic [31:0] mem [1<<AW];
  always @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (rd) rdata <= mem[addr];
  end
endmodule

module tb_fwrisc_imem_responder;
  localparam int AW = 12;
  localparam int NI = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [31:0]   iaddr     [NI];
  logic          ivalid    [NI];
  logic [31:0]   idata     [NI];
  logic          iready    [NI];
  logic [AW-1:0] mem_addr  [NI];
  logic          mem_rd    [NI];
  logic [31:0]   mem_rdata [NI];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      fwrisc_imem_responder #(
        .WAIT_STATES(gi * 3), .MEM_ADDR_W(AW), .SPLIT_MISALIGNED(1)
      ) u_dut (
        .clock(clock), .reset(reset), .iaddr(iaddr[gi]), .ivalid(ivalid[gi]),
        .idata(idata[gi]), .iready(iready[gi]), .mem_addr(mem_addr[gi]),
        .mem_rd(mem_rd[gi]), .mem_rdata(mem_rdata[gi])
      );
      fwrisc_imem_sram_model #(.AW(AW)) u_mem (
        .clock(clock), .rd(mem_rd[gi]), .addr(mem_addr[gi]), .rdata(mem_rdata[gi]),
        .we(mem_we), .waddr(mem_waddr), .wdata(mem_wdata)
      );
    end
  endgenerate

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Transaction model: k counts cycles since the accepting edge; instance i
  // has i*3 wait states, reads occupy k = W+1 (.. W+2 if split), response at W+2+split.
  logic [31:0]   shadow  [1<<AW];
  logic          m_busy  [NI] = '{default: 1'b0};
  int            m_k     [NI] = '{default: 0};
  logic [AW-1:0] m_wa    [NI] = '{default: '0};
  logic          m_split [NI] = '{default: 1'b0};

  always @(posedge clock or negedge reset) begin
    for (int i = 0; i < NI; i++) begin
      if (!reset) begin
        m_busy[i] <= 1'b0;
        m_k[i]    <= 0;
      end else if (!m_busy[i]) begin
        if (ivalid[i]) begin
          m_busy[i]  <= 1'b1;
          m_k[i]     <= 1;
          m_wa[i]    <= iaddr[i][AW+1:2];
          m_split[i] <= iaddr[i][1];
        end
      end else if (m_k[i] >= 2 + i * 3 + int'(m_split[i])) begin
        m_busy[i] <= 1'b0;
      end else begin
        m_k[i] <= m_k[i] + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic compare_cycle();
    int k, w, s;
    bit busy, erd, erdy;
    logic [AW-1:0] ea, wa1;
    logic [31:0] ed;
    for (int i = 0; i < NI; i++) begin
      k    = m_k[i];
      w    = i * 3;
      s    = int'(m_split[i]);
      busy = (m_busy[i] === 1'b1);
      erd  = busy && k >= w + 1 && k <= w + 1 + s;
      ea   = erd ? m_wa[i] + AW'(k - w - 1) : '0;
      erdy = busy && k == w + 2 + s;
      wa1  = m_wa[i] + AW'(1);
      ed   = !erdy ? 32'h0 : (s != 0) ? {shadow[wa1][15:0], shadow[m_wa[i]][31:16]}
                                      : shadow[m_wa[i]];
      chk($sformatf("inst%0d mem_rd", i), 32'(mem_rd[i]), 32'(erd));
      chk($sformatf("inst%0d mem_addr", i), 32'(mem_addr[i]), 32'(ea));
      chk($sformatf("inst%0d iready", i), 32'(iready[i]), 32'(erdy));
      chk($sformatf("inst%0d idata", i), idata[i], ed);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    @(posedge clock); #2;
    mem_we = 1'b1; mem_waddr = a; mem_wdata = d; shadow[a] = d;
    @(posedge clock); #2;
    mem_we = 1'b0;
  endtask

  // lat and rd_first are in edges after the accepting edge; redge is absolute.
  task automatic fetch(input int i, input logic [31:0] addr, input bit hold, input bit wiggle,
                       output int lat, output logic [31:0] data, output int rd_first,
                       output int rd_n, output logic [AW-1:0] a0, output logic [AW-1:0] a1,
                       output int redge);
    int t;
    @(posedge clock); #2;
    ivalid[i] = 1'b1; iaddr[i] = addr; t = cyc + 1;
    lat = -1; rd_first = -1; rd_n = 0; a0 = '1; a1 = '1; data = 'x; redge = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (wiggle && cyc == t) begin ivalid[i] = 1'b0; iaddr[i] = 32'h20; end
      if (mem_rd[i]) begin
        if (rd_first < 0) rd_first = cyc + 1 - t;
        if (rd_n == 0) a0 = mem_addr[i]; else a1 = mem_addr[i];
        rd_n++;
      end
      if (iready[i]) begin
        lat = cyc + 1 - t; redge = cyc + 1; data = idata[i];
        break;
      end
    end
    $display("fetch inst%0d addr=%h lat=%0d data=%h reads=%0d", i, addr, lat, data, rd_n);
    if (!hold) begin @(posedge clock); #2; ivalid[i] = 1'b0; end
  endtask

  initial begin
    int lat, rf, rn, e0, e1, e2, pulses;
    logic [31:0] d;
    logic [AW-1:0] a0, a1;
    for (int i = 0; i < NI; i++) begin ivalid[i] = 1'b0; iaddr[i] = '0; end
    mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    #1 reset = 1'b0;
    fork
      begin
        while (!done) begin @(negedge clock); compare_cycle(); end
      end
      begin
        load(12'h000, 32'h0000_0013);
        load(12'h001, 32'hBBBB_AAAA);
        load(12'h002, 32'hDDDD_CCCC);
        load(12'h003, 32'h1111_2222);
        load(12'h004, 32'hCAFE_0004);
        load(12'hFFF, 32'h7777_6666);
        @(negedge clock);
        chk("reset iready", 32'(iready[0]), 32'h0);
        chk("reset mem_addr", 32'(mem_addr[0]), 32'h0);
        #1 reset = 1'b1;

        fetch(0, 32'h0, 0, 0, lat, d, rf, rn, a0, a1, e0);
        chk("aligned lat", lat, 2); chk("aligned data", d, 32'h0000_0013);
        chk("aligned reads", rn, 1); chk("aligned addr", 32'(a0), 0);

        fetch(0, 32'h6, 0, 0, lat, d, rf, rn, a0, a1, e0);
        chk("split lat", lat, 3); chk("split data", d, 32'hCCCC_BBBB);
        chk("split addr0", 32'(a0), 1); chk("split addr1", 32'(a1), 2);

        fetch(0, 32'h3FFE, 0, 0, lat, d, rf, rn, a0, a1, e0);
        chk("wrap lat", lat, 3); chk("wrap addr1", 32'(a1), 0);
        chk("wrap data", d, 32'h0013_7777);

        fetch(0, 32'h0, 1, 0, lat, d, rf, rn, a0, a1, e0);
        chk("b2b data0", d, 32'h0000_0013);
        fetch(0, 32'h4, 1, 0, lat, d, rf, rn, a0, a1, e1);
        chk("b2b data1", d, 32'hBBBB_AAAA); chk("b2b gap1", e1 - e0, 3);
        fetch(0, 32'h8, 0, 0, lat, d, rf, rn, a0, a1, e2);
        chk("b2b data2", d, 32'hDDDD_CCCC); chk("b2b gap2", e2 - e0, 6);

        fetch(0, 32'hFFFF_0008, 0, 0, lat, d, rf, rn, a0, a1, e0);
        chk("alias data", d, 32'hDDDD_CCCC);
        fetch(0, 32'h4, 0, 1, lat, d, rf, rn, a0, a1, e0);
        chk("wiggle lat", lat, 2); chk("wiggle data", d, 32'hBBBB_AAAA);

        fetch(1, 32'h10, 0, 0, lat, d, rf, rn, a0, a1, e0);
        chk("wait3 first rd", rf, 4); chk("wait3 lat", lat, 5);
        chk("wait3 data", d, 32'hCAFE_0004);
        fetch(1, 32'h2, 0, 0, lat, d, rf, rn, a0, a1, e0);
        chk("wait3 split lat", lat, 6); chk("wait3 split data", d, 32'hAAAA_0000);

        // Reset while the second word of a split fetch is being read.
        @(posedge clock); #2;
        ivalid[0] = 1'b1; iaddr[0] = 32'h6;
        @(posedge clock); @(posedge clock);
        @(negedge clock);
        chk("rd1 mem_rd", 32'(mem_rd[0]), 32'h1); chk("rd1 mem_addr", 32'(mem_addr[0]), 32'h2);
        #1 reset = 1'b0; ivalid[0] = 1'b0;
        #1;
        chk("rst iready", 32'(iready[0]), 32'h0); chk("rst idata", idata[0], 32'h0);
        chk("rst mem_rd", 32'(mem_rd[0]), 32'h0); chk("rst mem_addr", 32'(mem_addr[0]), 32'h0);
        pulses = 0;
        repeat (2) begin @(negedge clock); if (iready[0]) pulses++; end
        #1 reset = 1'b1;
        repeat (4) begin @(negedge clock); if (iready[0]) pulses++; end
        chk("rst no pulse", pulses, 0);
        fetch(0, 32'h0, 0, 0, lat, d, rf, rn, a0, a1, e0);
        chk("post-rst lat", lat, 2); chk("post-rst data", d, 32'h0000_0013);

        repeat (3) @(posedge clock);
        done = 1'b1;
      end
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
